dclk_mode_ctrl: RTL and testbench

- Parametrised successor to the two-way display-clock select: sequences glitch-safe switching among NUM_MODES display-clock outputs of the clock core (MMCM + BUFGMUX tree).
- Holds the display pipeline in reset across each switch, then waits for settle time and MMCM lock before releasing it.
- Reports lock loss and lock timeouts.
- Runs entirely on the 100MHz system clock.

---
 rtl/dclk_mode_ctrl.sv | 152 +++++++++++++++
 tb/tb_dclk_mode_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dclk_mode_ctrl.sv
// Sequences glitch-safe switching among NUM_MODES display clocks: drain the
// display pipeline, move the BUFGMUX select, settle, then wait for MMCM lock.
module dclk_mode_ctrl #(
    parameter int NUM_MODES     = 4,
    parameter int SEL_W         = $clog2(NUM_MODES),
    parameter int DEFAULT_MODE  = 0,
    parameter int DRAIN_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] req_mode,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             mmcm_locked,
    output logic [SEL_W-1:0] clk_sel,
    output logic             disp_rst_n,
    output logic [SEL_W-1:0] cur_mode,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_badmode,
    output logic             lock_lost
);

    localparam int MAX_DS  = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (MAX_DS > LOCK_TIMEOUT) ? MAX_DS : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] DEF_SEL      = SEL_W'(DEFAULT_MODE);
    localparam logic [SEL_W:0]   MODE_LIMIT   = (SEL_W + 1)'(NUM_MODES);

    typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, WAIT_LOCK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pend_mode;
    logic             lock_s1;
    logic             lock_sync;

    // mmcm_locked comes from the MMCM with no relation to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_s1   <= mmcm_locked;
            lock_sync <= lock_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            pend_mode   <= DEF_SEL;
            clk_sel     <= DEF_SEL;
            cur_mode    <= DEF_SEL;
            disp_rst_n  <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_badmode <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden below in the same block.
            done        <= 1'b0;
            err_badmode <= 1'b0;
            lock_lost   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (disp_rst_n && !lock_sync) begin
                        // Lock loss wins over a same-cycle request, which is left unconsumed.
                        state      <= WAIT_LOCK;
                        cnt        <= '0;
                        disp_rst_n <= 1'b0;
                        lock_lost  <= 1'b1;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end else if (req_valid && req_ready) begin
                        if ({1'b0, req_mode} >= MODE_LIMIT) begin
                            err_badmode <= 1'b1;
                        end else if (req_mode == cur_mode && disp_rst_n) begin
                            done <= 1'b1;
                        end else begin
                            state       <= DRAIN;
                            cnt         <= '0;
                            pend_mode   <= req_mode;
                            disp_rst_n  <= 1'b0;
                            err_timeout <= 1'b0;
                            req_ready   <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state   <= SETTLE;
                        cnt     <= '0;
                        clk_sel <= pend_mode;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (lock_sync) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        disp_rst_n <= 1'b1;
                        cur_mode   <= clk_sel;
                        done       <= 1'b1;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        // Give up with the display still held in reset; a new request retries.
                        state       <= IDLE;
                        cnt         <= '0;
                        cur_mode    <= clk_sel;
                        err_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dclk_mode_ctrl.sv
// Directed bench for dclk_mode_ctrl with NUM_MODES=3 and LOCK_TIMEOUT=100.
module tb_dclk_mode_ctrl;

    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SEL_W-1:0] req_mode;
    logic             req_valid;
    logic             req_ready;
    logic             mmcm_locked;
    logic [SEL_W-1:0] clk_sel;
    logic             disp_rst_n;
    logic [SEL_W-1:0] cur_mode;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_badmode;
    logic             lock_lost;

    int n_checks = 0;
    int n_fail   = 0;

    dclk_mode_ctrl #(
        .NUM_MODES    (3),
        .SEL_W        (SEL_W),
        .DEFAULT_MODE (0),
        .DRAIN_CYCLES (8),
        .SETTLE_CYCLES(16),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_mode   (req_mode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mmcm_locked(mmcm_locked),
        .clk_sel    (clk_sel),
        .disp_rst_n (disp_rst_n),
        .cur_mode   (cur_mode),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .err_badmode(err_badmode),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1ns after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Packs {clk_sel, cur_mode, disp_rst_n, req_ready, busy, done, err_timeout, err_badmode, lock_lost}.
    function automatic logic [10:0] snap();
        return {clk_sel, cur_mode, disp_rst_n, req_ready, busy, done, err_timeout, err_badmode, lock_lost};
    endfunction

    task automatic expect_state(input string name, input logic [10:0] exp);
        n_checks++;
        if (snap() !== exp) begin
            n_fail++;
            $display("FAIL %s: got sel/cur/drst/rdy/busy/done/tmo/bad/lost=%b_%b_%b%b%b%b%b%b%b required %b_%b_%b%b%b%b%b%b%b",
                     name, clk_sel, cur_mode, disp_rst_n, req_ready, busy, done, err_timeout,
                     err_badmode, lock_lost, exp[10:9], exp[8:7], exp[6], exp[5], exp[4],
                     exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic request(input logic [SEL_W-1:0] mode);
        req_mode  = mode;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; mmcm_locked = 1'b0;
        #23;
        expect_state("reset_values", {2'd0, 2'd0, 7'b0010000});
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_boot();
        tick(4);
        expect_state("boot_waiting", {2'd0, 2'd0, 7'b0010000});
        mmcm_locked = 1'b1;
        tick(2);
        expect_state("boot_sync_latency", {2'd0, 2'd0, 7'b0010000});
        tick();
        expect_state("boot_done", {2'd0, 2'd0, 7'b1101000});
        tick();
        expect_state("boot_idle", {2'd0, 2'd0, 7'b1100000});
    endtask

    task automatic test_switch();
        int early;
        request(2'd2);
        expect_state("switch_accept", {2'd0, 2'd0, 7'b0010000});
        tick(7);
        expect_state("switch_drain_end", {2'd0, 2'd0, 7'b0010000});
        tick();
        expect_state("switch_sel_change", {2'd2, 2'd0, 7'b0010000});
        mmcm_locked = 1'b0;
        tick(11);
        mmcm_locked = 1'b1;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0 || disp_rst_n !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL switch_settle_floor: got %0d early completion cycles required 0", early);
        end
        tick();
        expect_state("switch_done", {2'd2, 2'd2, 7'b1101000});
    endtask

    task automatic test_same_mode();
        request(2'd2);
        expect_state("same_mode_done", {2'd2, 2'd2, 7'b1101000});
        tick();
        expect_state("same_mode_after", {2'd2, 2'd2, 7'b1100000});
    endtask

    task automatic test_badmode();
        request(2'd3);
        expect_state("badmode_pulse", {2'd2, 2'd2, 7'b1100010});
        tick();
        expect_state("badmode_after", {2'd2, 2'd2, 7'b1100000});
    endtask

    task automatic test_lock_loss();
        mmcm_locked = 1'b0;
        tick(2);
        expect_state("lockloss_before", {2'd2, 2'd2, 7'b1100000});
        req_mode  = 2'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        expect_state("lockloss_pulse", {2'd2, 2'd2, 7'b0010001});
        tick(20);
        expect_state("lockloss_waiting", {2'd2, 2'd2, 7'b0010000});
        mmcm_locked = 1'b1;
        tick(3);
        expect_state("lockloss_relock", {2'd2, 2'd2, 7'b1101000});
    endtask

    task automatic test_timeout();
        request(2'd1);
        mmcm_locked = 1'b0;
        expect_state("timeout_accept", {2'd2, 2'd2, 7'b0010000});
        tick(123);
        expect_state("timeout_before", {2'd1, 2'd2, 7'b0010000});
        tick();
        expect_state("timeout_flag", {2'd1, 2'd1, 7'b0100100});
        mmcm_locked = 1'b1;
        tick(4);
        expect_state("timeout_sticky", {2'd1, 2'd1, 7'b0100100});
    endtask

    task automatic test_back_to_back();
        request(2'd1);
        expect_state("retry_same_mode_full_path", {2'd1, 2'd1, 7'b0010000});
        tick(2);
        request(2'd2);
        tick(5);
        expect_state("retry_sel_change", {2'd1, 2'd1, 7'b0010000});
        tick(3);
        rst_n = 1'b0;
        #1;
        expect_state("reset_mid_settle", {2'd0, 2'd0, 7'b0010000});
        tick();
        rst_n = 1'b1;
        tick(3);
        expect_state("reboot_done", {2'd0, 2'd0, 7'b1101000});
    endtask

    initial begin
        test_reset();
        test_boot();
        test_switch();
        test_same_mode();
        test_badmode();
        test_lock_loss();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
